// File: rtl/shield_monitor.sv
// -----------------------------------------------------------------------------
// shield_monitor
//
// Watches a safety shield that sits between an agent and the plant. Each cycle
// it compares the agent's proposed actions against the shield's corrected
// actions. It then reports overrides, counts them, flags a shield that keeps
// overriding, and checks that the corrected actions stay mutually exclusive.
// Interesting cycles are queued as 8-bit event records for the agent to read
// through a valid/ready port.
//
// Ports
//   clock         in   sole clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   u1            in   uncontrollable input
//   l1, l2, l3    in   proposed actions P = {l1,l2,l3}
//   l1__1..l3__1  in   corrected actions C = {l1__1,l2__1,l3__1}
//   evt_valid     out  event record available (FIFO non-empty)
//   evt_ready     in   consumer accepts the head record
//   evt_data      out  head record {u1, P, C, mutex_err}
//   override      out  registered (P != C)
//   ovr_count     out  saturating override counter
//   drop_count    out  saturating count of records lost to a full FIFO
//   stuck         out  shield has overridden STUCK_LIM cycles in a row
//   mutex_viol    out  sticky: C had more than one bit set at some point
//   overflow      out  sticky: a record was dropped at some point
//
// Streak FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_MATCH | last sample had P == C, streak = 0
//   ST_OVR   | overriding, streak counts consecutive overrides
//   ST_STUCK | STUCK_LIM consecutive overrides seen, stuck asserted
// -----------------------------------------------------------------------------
module shield_monitor #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int STUCK_LIM  = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             u1,
    input  logic             l1,
    input  logic             l2,
    input  logic             l3,
    input  logic             l1__1,
    input  logic             l2__1,
    input  logic             l3__1,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_data,
    output logic             override,
    output logic [CNT_W-1:0] ovr_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             stuck,
    output logic             mutex_viol,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STUCK_LIM + 1);

    typedef enum logic [1:0] {
        ST_MATCH = 2'd0,
        ST_OVR   = 2'd1,
        ST_STUCK = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    logic [2:0] prop_vec;
    logic [2:0] corr_vec;
    logic       ovr_now;
    logic       mutex_now;
    logic [7:0] rec_in;

    assign prop_vec  = {l1, l2, l3};
    assign corr_vec  = {l1__1, l2__1, l3__1};
    assign ovr_now   = (prop_vec != corr_vec);
    // More than one bit set in a 3-bit vector means at least one pair is set.
    assign mutex_now = (corr_vec[0] & corr_vec[1]) |
                       (corr_vec[0] & corr_vec[2]) |
                       (corr_vec[1] & corr_vec[2]);
    assign rec_in    = {u1, prop_vec, corr_vec, mutex_now};

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;

    assign push  = ovr_now | mutex_now;
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = evt_valid & evt_ready;
    // A full FIFO can still take a record when the head leaves on the same edge.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the output is masked whenever the FIFO is empty,
    // and a reset empties it.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= rec_in;
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 8'h00;

    // ------------------------------------------------------------------
    // Override flag, saturating counters, sticky flags
    // ------------------------------------------------------------------
    logic             override_q, override_d;
    logic [CNT_W-1:0] ovr_count_q, ovr_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             mutex_viol_q, mutex_viol_d;
    logic             overflow_q, overflow_d;

    always_comb begin
        override_d   = ovr_now;
        ovr_count_d  = ovr_count_q;
        drop_count_d = drop_count_q;
        mutex_viol_d = mutex_viol_q | mutex_now;
        overflow_d   = overflow_q | drop;
        if (ovr_now && (ovr_count_q != '1)) begin
            ovr_count_d = ovr_count_q + CNT_W'(1);
        end
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            override_q   <= 1'b0;
            ovr_count_q  <= '0;
            drop_count_q <= '0;
            mutex_viol_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            override_q   <= override_d;
            ovr_count_q  <= ovr_count_d;
            drop_count_q <= drop_count_d;
            mutex_viol_q <= mutex_viol_d;
            overflow_q   <= overflow_d;
        end
    end

    assign override   = override_q;
    assign ovr_count  = ovr_count_q;
    assign drop_count = drop_count_q;
    assign mutex_viol = mutex_viol_q;
    assign overflow   = overflow_q;

    // ------------------------------------------------------------------
    // Streak FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [SW-1:0] streak_inc;

    assign streak_inc = streak_q + SW'(1);

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            ST_MATCH: begin
                if (ovr_now) begin
                    streak_d = SW'(1);
                    // A limit of one means the very first override is stuck.
                    state_d  = (STUCK_LIM <= 1) ? ST_STUCK : ST_OVR;
                end
            end
            ST_OVR: begin
                if (ovr_now) begin
                    streak_d = streak_inc;
                    if (streak_inc == SW'(STUCK_LIM)) begin
                        state_d = ST_STUCK;
                    end
                end else begin
                    streak_d = '0;
                    state_d  = ST_MATCH;
                end
            end
            ST_STUCK: begin
                if (!ovr_now) begin
                    streak_d = '0;
                    state_d  = ST_MATCH;
                end
            end
            default: begin
                streak_d = '0;
                state_d  = ST_MATCH;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_MATCH;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    assign stuck = (state_q == ST_STUCK);

endmodule

// File: tb/tb_shield_monitor.sv
// -----------------------------------------------------------------------------
// tb_shield_monitor
//
// Directed bench for shield_monitor. Stimulus pushes the expected event
// records into a queue as it issues them. A negedge monitor pops and compares
// on every valid/ready handshake. Status outputs are checked against
// hand-computed constants at fixed points. The counters are built 4 bits wide
// so that override saturation is reached.
// -----------------------------------------------------------------------------
module tb_shield_monitor;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          u1, l1, l2, l3;
    logic          l1__1, l2__1, l3__1;
    logic          evt_valid;
    logic          evt_ready;
    logic [7:0]    evt_data;
    logic          override;
    logic [CW-1:0] ovr_count;
    logic [CW-1:0] drop_count;
    logic          stuck;
    logic          mutex_viol;
    logic          overflow;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    shield_monitor #(
        .FIFO_DEPTH(4),
        .CNT_W     (CW),
        .STUCK_LIM (8)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .u1        (u1),
        .l1        (l1),
        .l2        (l2),
        .l3        (l3),
        .l1__1     (l1__1),
        .l2__1     (l2__1),
        .l3__1     (l3__1),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .override  (override),
        .ovr_count (ovr_count),
        .drop_count(drop_count),
        .stuck     (stuck),
        .mutex_viol(mutex_viol),
        .overflow  (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic u, input logic [2:0] p, input logic [2:0] c);
        u1 = u;
        {l1, l2, l3} = p;
        {l1__1, l2__1, l3__1} = c;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " evt_valid"},  evt_valid,  0);
        chk({tag, " evt_data"},   evt_data,   0);
        chk({tag, " override"},   override,   0);
        chk({tag, " ovr_count"},  ovr_count,  0);
        chk({tag, " drop_count"}, drop_count, 0);
        chk({tag, " stuck"},      stuck,      0);
        chk({tag, " mutex_viol"}, mutex_viol, 0);
        chk({tag, " overflow"},   overflow,   0);
    endtask

    // Scoreboard monitor: a handshake seen at the negedge completes on the
    // next rising edge, so the head record is compared here.
    always @(negedge clock) begin : monitor
        logic [7:0] ev;
        if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_record: got %0h, expected none (t=%0t)", evt_data, $time);
            end else begin
                ev = exp_q.pop_front();
                if (evt_data !== ev) begin
                    n_fail++;
                    $display("FAIL record: got %0h, expected %0h (t=%0t)", evt_data, ev, $time);
                end
            end
        end
    end

    initial begin
        logic [7:0] recs [6];
        recs = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};

        // Reset state
        rst_n = 1'b0;
        evt_ready = 1'b0;
        u1 = 0; l1 = 0; l2 = 0; l3 = 0; l1__1 = 0; l2__1 = 0; l3__1 = 0;
        #2;
        chk_all_zero("reset");
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        // Steady match, P = C = 100
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 3'b100, 3'b100);
            chk("match override", override, 0);
        end
        chk("match ovr_count", ovr_count, 0);
        chk("match evt_valid", evt_valid, 0);
        chk("match stuck", stuck, 0);

        // Single override, record 1110_1000
        cyc(1'b1, 3'b110, 3'b100);
        exp_q.push_back(8'hE8);
        chk("single override", override, 1);
        chk("single evt_valid", evt_valid, 1);
        chk("single evt_data", evt_data, 8'hE8);
        chk("single ovr_count", ovr_count, 1);
        cyc(1'b0, 3'b100, 3'b100);
        chk("single popped", evt_valid, 0);
        chk("single override clr", override, 0);

        // Six overrides with no consumer: four kept, two dropped
        evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 3'(i + 1), 3'b000);
            if (i < 4) exp_q.push_back(recs[i]);
            chk("ovf head stable", evt_data, 8'h10);
            chk("ovf evt_valid", evt_valid, 1);
        end
        chk("ovf drop_count", drop_count, 2);
        chk("ovf overflow", overflow, 1);
        chk("ovf ovr_count", ovr_count, 7);
        chk("ovf stuck", stuck, 0);
        evt_ready = 1'b1;
        repeat (4) cyc(1'b0, 3'b000, 3'b000);
        chk("ovf drained", evt_valid, 0);
        chk("ovf overflow sticky", overflow, 1);

        // Eight overrides -> stuck; one match clears it
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 3'b001, 3'b000);
            exp_q.push_back(8'h10);
            chk("stuck8", stuck, (k == 8) ? 1 : 0);
        end
        chk("stuck8 ovr_count", ovr_count, 15);
        cyc(1'b0, 3'b000, 3'b000);
        chk("stuck cleared", stuck, 0);

        // Seven overrides then a match: never stuck; ovr_count saturates
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b0, 3'b001, 3'b000);
            exp_q.push_back(8'h10);
            chk("stuck7", stuck, 0);
        end
        cyc(1'b0, 3'b000, 3'b000);
        chk("stuck7 match", stuck, 0);
        chk("ovr_count saturated", ovr_count, 15);
        chk("drop_count unchanged", drop_count, 2);

        // Mutex violation without override, record 1011_0111
        chk("mutex before", mutex_viol, 0);
        cyc(1'b1, 3'b011, 3'b011);
        exp_q.push_back(8'hB7);
        chk("mutex override", override, 0);
        chk("mutex flag", mutex_viol, 1);
        chk("mutex evt_valid", evt_valid, 1);
        chk("mutex evt_data", evt_data, 8'hB7);
        chk("mutex ovr_count", ovr_count, 15);
        cyc(1'b0, 3'b000, 3'b000);
        chk("mutex sticky", mutex_viol, 1);
        chk("mutex drained", evt_valid, 0);

        // Full FIFO with simultaneous push and pop: no drop
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 3'(i + 1), 3'b000);
            exp_q.push_back(recs[i]);
        end
        chk("full no drop yet", drop_count, 2);
        evt_ready = 1'b1;
        cyc(1'b0, 3'b111, 3'b000);
        exp_q.push_back(8'h70);
        chk("push+pop drop_count", drop_count, 2);
        chk("push+pop head", evt_data, 8'h20);
        repeat (4) cyc(1'b0, 3'b000, 3'b000);
        chk("push+pop drained", evt_valid, 0);

        // Reset mid-operation with three records queued and stuck high
        for (int k = 1; k <= 8; k++) begin
            if (k == 7) evt_ready = 1'b0;
            cyc(1'b0, 3'b001, 3'b000);
            exp_q.push_back(8'h10);
        end
        chk("pre-reset stuck", stuck, 1);
        chk("pre-reset evt_valid", evt_valid, 1);
        chk("pre-reset override", override, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_q.delete();
        u1 = 0; l1 = 0; l2 = 0; l3 = 0; l1__1 = 0; l2__1 = 0; l3__1 = 0;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        evt_ready = 1'b1;
        cyc(1'b0, 3'b000, 3'b000);
        chk_all_zero("post-reset");

        // Sampling resumes after release
        cyc(1'b1, 3'b110, 3'b100);
        exp_q.push_back(8'hE8);
        chk("resume override", override, 1);
        chk("resume ovr_count", ovr_count, 1);
        chk("resume evt_valid", evt_valid, 1);
        cyc(1'b0, 3'b000, 3'b000);
        chk("resume drained", evt_valid, 0);
        chk("records outstanding", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shield_monitor.md
SHIELD_MONITOR -- requirements
Module: shield_monitor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning event buffer entries (power of two, at least 2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the saturating override and drop counters.
REQ-003 SHALL have parameter STUCK_LIM, default 8, meaning the consecutive-override cycle count that declares the shield stuck.
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports u1, l1, l2, l3  input  1 each  uncontrollable input and the agent's proposed actions, as presented to the shield.
REQ-007 SHALL have ports l1__1, l2__1, l3__1  input  1 each  the shield's corrected actions for the same cycle.
REQ-008 SHALL have port evt_valid  output  1  event record available.
REQ-009 SHALL have port evt_ready  input  1  the agent accepts the record.
REQ-010 SHALL have port evt_data  output  8  event record {u1, l1, l2, l3, l1__1, l2__1, l3__1, mutex_err}.
REQ-011 SHALL have ports override  output  1, ovr_count  output  CNT_W, drop_count  output  CNT_W, stuck  output  1, mutex_viol  output  1, overflow  output  1.

Function
REQ-012 SHALL sample all inputs on every rising clock edge; the proposed vector P is {l1,l2,l3} and the corrected vector C is {l1__1,l2__1,l3__1}.
REQ-013 SHALL register override = (P != C) and present it the cycle after sampling (1-cycle latency).
REQ-014 SHALL compute mutex_err = more than one bit of C set, and SHALL set sticky mutex_viol on the edge where mutex_err is sampled true.
REQ-015 SHALL increment ovr_count on each sampled override and saturate at all-ones with no wrap.
REQ-016 SHALL push one record per sampled override, or per sampled mutex_err, onto a FIFO_DEPTH-entry FIFO.
REQ-017 SHALL drive evt_valid = FIFO non-empty and evt_data = head entry, with no combinational path from any input to evt_data.
REQ-018 SHALL pop the head on an edge where evt_valid and evt_ready are both high.
REQ-019 SHALL hold evt_data stable while evt_valid is high and evt_ready is low.
REQ-020 SHALL, on a push with the FIFO full and no pop in the same edge, discard the new record, increment drop_count (saturating) and set sticky overflow.
REQ-021 SHALL, on a push and pop in the same edge with the FIFO full, perform both with no drop.
REQ-022 SHALL give a record pushed into an empty FIFO evt_valid high on the following cycle.
REQ-023 SHALL implement streak FSM states MATCH, OVR and STUCK, with a streak counter wide enough for STUCK_LIM.
REQ-024 SHALL, in MATCH, go to OVR with streak=1 on a sampled override, and otherwise stay in MATCH.
REQ-025 SHALL, in OVR, increment streak on an override and go to STUCK when streak reaches STUCK_LIM, and SHALL return to MATCH with streak=0 on a match.
REQ-026 SHALL, in STUCK, drive stuck=1 and return to MATCH with streak=0 only on a sampled match.
REQ-027 SHALL have stuck decoded from the registered state, so it is high exactly while the state is STUCK.
REQ-028 SHALL keep mutex_viol and overflow sticky until reset.

Reset
REQ-029 SHALL, while rst_n is low, immediately force FIFO empty, evt_valid=0, evt_data=0, override=0, ovr_count=0, drop_count=0, stuck=0, mutex_viol=0, overflow=0, state=MATCH, streak=0.
REQ-030 SHALL discard records in flight on reset asserted mid-operation, with no partial pop.
REQ-031 SHALL resume sampling on the first rising edge after rst_n is released.

Verification
REQ-032 SHALL cover: P=C=100 for 10 cycles -> override=0, ovr_count=0, evt_valid=0, state MATCH.
REQ-033 SHALL cover: single cycle with u1=1, P=110, C=100, evt_ready=1 -> next cycle override=1, evt_valid=1, evt_data=8'b1110_1000; popped one cycle later; ovr_count=1.
REQ-034 SHALL cover: 6 consecutive overrides with evt_ready=0 -> 4 records held in order, drop_count=2, overflow=1, evt_data constant.
REQ-035 SHALL cover: overrides on 8 consecutive cycles -> stuck=1 after the 8th sample; one match -> stuck=0 next cycle; 7 overrides then a match -> stuck never asserts.
REQ-036 SHALL cover: C=011 with P=011 -> record pushed with bit0=1, mutex_viol=1, override=0, ovr_count unchanged.
REQ-037 SHALL cover: rst_n pulsed low mid-cycle with 3 records queued and stuck=1 -> all outputs 0 before the next edge, FIFO empty after release.
